// File: rtl/intc_8051.sv
// 8051-style interrupt controller: source latching, IE/IP SFRs, two-level priority arbitration,
// vector request handshake to the PC. Optional ack watchdog under `INTC_ACK_TIMEOUT_EN`.
module intc_8051 #(
`ifdef INTC_ACK_TIMEOUT_EN
    parameter int unsigned ACK_TIMEOUT = 15,
`endif
    parameter logic [7:0] ADDR_IE = 8'hA8,
    parameter logic [7:0] ADDR_IP = 8'hB8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic       it0,
    input  logic       it1,
    input  logic       tf0,
    input  logic       tf1,
    input  logic       ri,
    input  logic       ti,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    input  logic       sfr_we,
    output logic [7:0] sfr_rdata,
    input  logic       int_ack,
    input  logic       reti,
    output logic       int_req,
    output logic [7:0] int_vec,
    output logic       clr_tf0,
    output logic       clr_tf1
`ifdef INTC_ACK_TIMEOUT_EN
    ,
    output logic       ack_err
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

    state_e      state_q, state_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  ip_q, ip_d;
    logic        int0_s1_q, int0_s2_q, int0_dly_q;
    logic        int1_s1_q, int1_s2_q, int1_dly_q;
    logic        ie0_lat_q, ie0_lat_d;
    logic        ie1_lat_q, ie1_lat_d;
    logic        in_hi_q, in_hi_d;
    logic        in_lo_q, in_lo_d;
    logic        lvl_q, lvl_d;
    logic [2:0]  src_q, src_d;
    logic        int_req_q, int_req_d;
    logic [7:0]  int_vec_q, int_vec_d;
    logic        clr_tf0_q, clr_tf0_d;
    logic        clr_tf1_q, clr_tf1_d;
`ifdef INTC_ACK_TIMEOUT_EN
    localparam logic [3:0] TimeoutLast = 4'(ACK_TIMEOUT - 1);
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_err_q, ack_err_d;
`endif

    logic        ie0_fall, ie1_fall;
    logic        acked, clr_ie0, clr_ie1;
    logic [4:0]  src_req, eligible, hi_req, lo_req;
    logic        win_valid, win_hi;
    logic [2:0]  win_idx;

    // Lowest index wins, matching the fixed polling order IE0, TF0, IE1, TF1, SER.
    function automatic logic [2:0] first_idx(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign ie0_fall = int0_dly_q & ~int0_s2_q;
    assign ie1_fall = int1_dly_q & ~int1_s2_q;
    assign acked    = (state_q == StReq) && int_ack;
    assign clr_ie0  = acked && (src_q == 3'd0);
    assign clr_ie1  = acked && (src_q == 3'd2);

    always_comb begin
        // A new edge arriving with the vector ack must not be lost, so set beats clear.
        ie0_lat_d = ie0_lat_q;
        if (!it0)          ie0_lat_d = 1'b0;
        else if (ie0_fall) ie0_lat_d = 1'b1;
        else if (clr_ie0)  ie0_lat_d = 1'b0;

        ie1_lat_d = ie1_lat_q;
        if (!it1)          ie1_lat_d = 1'b0;
        else if (ie1_fall) ie1_lat_d = 1'b1;
        else if (clr_ie1)  ie1_lat_d = 1'b0;

        src_req[0] = it0 ? (ie0_lat_q | ie0_fall) : ~int0_s2_q;
        src_req[1] = tf0;
        src_req[2] = it1 ? (ie1_lat_q | ie1_fall) : ~int1_s2_q;
        src_req[3] = tf1;
        src_req[4] = ri | ti;
    end

    always_comb begin
        eligible  = src_req & ie_q[4:0] & {5{ie_q[7]}};
        hi_req    = eligible & ip_q;
        lo_req    = eligible & ~ip_q;
        win_valid = 1'b0;
        win_hi    = 1'b0;
        win_idx   = 3'd0;
        if ((|hi_req) && !in_hi_q) begin
            win_valid = 1'b1;
            win_hi    = 1'b1;
            win_idx   = first_idx(hi_req);
        end else if ((|lo_req) && !in_hi_q && !in_lo_q) begin
            win_valid = 1'b1;
            win_idx   = first_idx(lo_req);
        end
    end

    always_comb begin
        ie_d      = ie_q;
        ip_d      = ip_q;
        state_d   = state_q;
        in_hi_d   = in_hi_q;
        in_lo_d   = in_lo_q;
        lvl_d     = lvl_q;
        src_d     = src_q;
        int_req_d = int_req_q;
        int_vec_d = int_vec_q;
        clr_tf0_d = 1'b0;
        clr_tf1_d = 1'b0;
`ifdef INTC_ACK_TIMEOUT_EN
        cnt_d     = cnt_q;
        ack_err_d = ack_err_q;
`endif

        if (sfr_we && (sfr_addr == ADDR_IE)) ie_d = sfr_wdata;
        if (sfr_we && (sfr_addr == ADDR_IP)) ip_d = sfr_wdata[4:0];

        if (reti) begin
            if (in_hi_q) in_hi_d = 1'b0;
            else         in_lo_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    int_req_d = 1'b1;
                    int_vec_d = {2'b00, win_idx, 3'b011};
                    src_d     = win_idx;
                    lvl_d     = win_hi;
                    state_d   = StReq;
`ifdef INTC_ACK_TIMEOUT_EN
                    cnt_d     = 4'd0;
`endif
                end
            end
            StReq: begin
                if (int_ack) begin
                    int_req_d = 1'b0;
                    if (lvl_q) in_hi_d = 1'b1;
                    else       in_lo_d = 1'b1;
                    clr_tf0_d = (src_q == 3'd1);
                    clr_tf1_d = (src_q == 3'd3);
                    state_d   = StWaitLow;
                end
`ifdef INTC_ACK_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    int_req_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            StWaitLow: begin
                if (!int_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ie_q       <= 8'h00;
            ip_q       <= 5'h00;
            int0_s1_q  <= 1'b1;
            int0_s2_q  <= 1'b1;
            int0_dly_q <= 1'b1;
            int1_s1_q  <= 1'b1;
            int1_s2_q  <= 1'b1;
            int1_dly_q <= 1'b1;
            ie0_lat_q  <= 1'b0;
            ie1_lat_q  <= 1'b0;
            in_hi_q    <= 1'b0;
            in_lo_q    <= 1'b0;
            lvl_q      <= 1'b0;
            src_q      <= 3'd0;
            int_req_q  <= 1'b0;
            int_vec_q  <= 8'h00;
            clr_tf0_q  <= 1'b0;
            clr_tf1_q  <= 1'b0;
`ifdef INTC_ACK_TIMEOUT_EN
            cnt_q      <= 4'd0;
            ack_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            int0_s1_q  <= int0_n;
            int0_s2_q  <= int0_s1_q;
            int0_dly_q <= int0_s2_q;
            int1_s1_q  <= int1_n;
            int1_s2_q  <= int1_s1_q;
            int1_dly_q <= int1_s2_q;
            ie0_lat_q  <= ie0_lat_d;
            ie1_lat_q  <= ie1_lat_d;
            in_hi_q    <= in_hi_d;
            in_lo_q    <= in_lo_d;
            lvl_q      <= lvl_d;
            src_q      <= src_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            clr_tf0_q  <= clr_tf0_d;
            clr_tf1_q  <= clr_tf1_d;
`ifdef INTC_ACK_TIMEOUT_EN
            cnt_q      <= cnt_d;
            ack_err_q  <= ack_err_d;
`endif
        end
    end

    always_comb begin
        if (sfr_addr == ADDR_IE)      sfr_rdata = ie_q;
        else if (sfr_addr == ADDR_IP) sfr_rdata = {3'b000, ip_q};
        else                          sfr_rdata = 8'h00;
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;
    assign clr_tf0 = clr_tf0_q;
    assign clr_tf1 = clr_tf1_q;
`ifdef INTC_ACK_TIMEOUT_EN
    assign ack_err = ack_err_q;
`endif

endmodule
